// File: rtl/dm_if.sv
// Request/response channel between the M-stage load/store port and its data memory.
interface dm_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, req_pc, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, req_pc, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder with programmable wait states; one request in flight,
// byte-merged stores, range/alignment error reporting and a store log.
module dm_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic clk,
  input logic reset,
  dm_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic        l_we;
  logic [31:0] l_addr, l_wdata, l_pc;
  logic [3:0]  l_be;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH_WORDS];

  // Commit source: live inputs when going straight from IDLE, latched copy otherwise.
  logic        c_we, c_err, enter_resp, accept;
  logic [31:0] c_addr, c_wdata, c_pc, c_old, c_merged;
  logic [3:0]  c_be;
  logic [32:0] c_off;
  logic [IW-1:0] c_idx;

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  assign accept = (state == S_IDLE) && bus.req_valid;

  always_comb begin
    c_we     = l_we;
    c_addr   = l_addr;
    c_wdata  = l_wdata;
    c_be     = l_be;
    c_pc     = l_pc;
    if (state == S_IDLE) begin
      c_we    = bus.req_we;
      c_addr  = bus.req_addr;
      c_wdata = bus.req_wdata;
      c_be    = bus.req_be;
      c_pc    = bus.req_pc;
    end
    // 33-bit offset: bit 32 set means the address lies below BASE_ADDR.
    c_off    = {1'b0, c_addr} - {1'b0, BASE_ADDR};
    c_err    = (c_addr[1:0] != 2'b00) || c_off[32] ||
               ({2'b00, c_off[31:2]} >= 32'(DEPTH_WORDS));
    c_idx    = c_off[IW+1:2];
    c_old    = c_err ? 32'h0 : mem[c_idx];
    c_merged = c_old;
    for (int i = 0; i < 4; i++)
      if (c_be[i]) c_merged[8*i +: 8] = c_wdata[8*i +: 8];
    enter_resp = (WAIT_CYCLES == 0) ? accept : ((state == S_WAIT) && (cnt == 8'd0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      l_we    <= 1'b0;
      l_addr  <= 32'h0;
      l_wdata <= 32'h0;
      l_be    <= 4'h0;
      l_pc    <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
    end else begin
      if (accept) begin
        l_we    <= bus.req_we;
        l_addr  <= bus.req_addr;
        l_wdata <= bus.req_wdata;
        l_be    <= bus.req_be;
        l_pc    <= bus.req_pc;
        // Counter runs WAIT_CYCLES..0 so rsp_valid rises WAIT_CYCLES+1 edges after accept.
        cnt     <= 8'(WAIT_CYCLES);
        if (WAIT_CYCLES != 0) state <= S_WAIT;
      end
      if (state == S_WAIT && cnt != 8'd0) cnt <= cnt - 8'd1;
      if (enter_resp) begin
        state   <= S_RESP;
        err_q   <= c_err;
        rdata_q <= (c_err || c_we) ? 32'h0 : c_old;
        if (c_we && !c_err) begin
          mem[c_idx] <= c_merged;
          $display("%d@%h: *%h <= %h", $time, c_pc, c_addr, c_merged);
        end
      end
      if (state == S_RESP && bus.rsp_ready) begin
        state   <= S_IDLE;
        rdata_q <= 32'h0;
        err_q   <= 1'b0;
      end
    end
  end
endmodule
